// File: rtl/blinker_pkg.sv
// Shared types and default constants for the turn-signal button conditioning path.
package blinker_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      DB_PRESS   = 2'd1,
      HELD       = 2'd2,
      DB_RELEASE = 2'd3
   } db_state_e;

   localparam int DEBOUNCE_CYCLES_DEF = 4;
   localparam int AUTO_OFF_CYCLES_DEF = 1024;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/blinker_switch_ctrl.sv
// Push-button -> synchronizer -> debounce FSM -> press-toggle level for the blinker.
// Optional timeout forcing the switch low: define BLINKER_AUTO_OFF_EN.
module blinker_switch_ctrl
   import blinker_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int AUTO_OFF_CYCLES = AUTO_OFF_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic btn_stable,
   output logic press_pulse,
   output logic blinker_switch
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES);

   if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
      $error("DEBOUNCE_CYCLES must be >= 1");
   end
   if (AUTO_OFF_CYCLES < 1) begin : g_bad_ao
      $error("AUTO_OFF_CYCLES must be >= 1");
   end

   logic btn_sync;

   sync_2ff u_sync (
      .clk   (clk),
      .rst_n (reset),
      .d     (btn_raw),
      .q     (btn_sync)
   );

   db_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stable_q, stable_d;
   logic             pulse_q, pulse_d;
   logic             bs_q, bs_d;

`ifdef BLINKER_AUTO_OFF_EN
   localparam int TO_W = (AUTO_OFF_CYCLES > 1) ? $clog2(AUTO_OFF_CYCLES) : 1;
   logic [TO_W-1:0] to_q, to_d;
   logic            timeout;

   assign timeout = bs_q && (to_q == TO_W'(AUTO_OFF_CYCLES - 1));
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      stable_d = stable_q;
      pulse_d  = 1'b0;
      bs_d     = bs_q;
      case (state_q)
         IDLE: begin
            if (btn_sync) begin
               state_d = DB_PRESS;
               cnt_d   = CNT_W'(1);
            end
         end
         DB_PRESS: begin
            if (!btn_sync) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == DB_MAX) begin
               state_d  = HELD;
               stable_d = 1'b1;
               pulse_d  = 1'b1;
               bs_d     = ~bs_q;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         HELD: begin
            if (!btn_sync) begin
               state_d = DB_RELEASE;
               cnt_d   = CNT_W'(1);
            end
         end
         DB_RELEASE: begin
            if (btn_sync) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_q == DB_MAX) begin
               state_d  = IDLE;
               stable_d = 1'b0;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
`ifdef BLINKER_AUTO_OFF_EN
      // Timeout wins over a same-edge press; the press still strobes.
      if (timeout) bs_d = 1'b0;
      // Counting only while the switch stays high clears it on the rising edge too.
      to_d = (bs_q && bs_d) ? to_q + 1'b1 : '0;
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         stable_q <= 1'b0;
         pulse_q  <= 1'b0;
         bs_q     <= 1'b0;
`ifdef BLINKER_AUTO_OFF_EN
         to_q     <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
         pulse_q  <= pulse_d;
         bs_q     <= bs_d;
`ifdef BLINKER_AUTO_OFF_EN
         to_q     <= to_d;
`endif
      end
   end

   assign btn_stable     = stable_q;
   assign press_pulse    = pulse_q;
   assign blinker_switch = bs_q;

endmodule

// File: doc/blinker_switch_ctrl.md
Name: blinker_switch_ctrl

Overview:
- Conditions the raw turn-signal push-button into the level `blinker_switch` consumed by the blinker stage directly downstream.
- Pipeline: 2-flop synchronizer, then counter-based debounce FSM, then a press-toggle register.
- Each debounced press toggles `blinker_switch`; a one-cycle `press_pulse` is provided for status logic.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive synchronized cycles the input must hold a new level before it is accepted; must be ≥1.
- AUTO_OFF_CYCLES, 1024, cycles `blinker_switch` may stay high before it is forced low; used only with BLINKER_AUTO_OFF_EN.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width; derived, not overridden.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, asynchronous active-low reset (0 = reset asserted).
- btn_raw, input, 1, raw asynchronous push-button level; 1 = pressed.
- btn_stable, output, 1, debounced button level.
- press_pulse, output, 1, one-cycle strobe on each accepted press (0→1 of btn_stable).
- blinker_switch, output, 1, toggled level feeding the blinker stage.

Behaviour:
- Reset (reset=0, asynchronous): sync flops=0, counter=0, FSM=IDLE, btn_stable=0, press_pulse=0, blinker_switch=0. All outputs are registered.
- Synchronizer: btn_sync is btn_raw delayed by 2 flops. The FSM sees only btn_sync.
- FSM states: IDLE (stable 0), DB_PRESS, HELD (stable 1), DB_RELEASE.
- IDLE: btn_sync=1 → DB_PRESS, counter←1. Otherwise stay.
- DB_PRESS: btn_sync=0 → IDLE, counter←0 (glitch rejected, no outputs change). btn_sync=1 and counter==DEBOUNCE_CYCLES → HELD, btn_stable←1, press_pulse←1, blinker_switch←~blinker_switch, counter←0. Otherwise counter+1.
- HELD: btn_sync=0 → DB_RELEASE, counter←1.
- DB_RELEASE: btn_sync=1 → HELD, counter←0. btn_sync=0 and counter==DEBOUNCE_CYCLES → IDLE, btn_stable←0, counter←0. Otherwise counter+1.
  - No pulse and no toggle on release.
- Latency: btn_raw steady high from edge k (first edge sampling it) gives btn_stable, press_pulse and the toggle visible after edge k+2+DEBOUNCE_CYCLES. Release latency is identical.
- press_pulse: high exactly one cycle per accepted press. A held button never re-pulses.
- Counter never exceeds DEBOUNCE_CYCLES; no wrap.
- DEBOUNCE_CYCLES=1: each transition needs a single confirming cycle.
- Reset mid-debounce: everything returns to reset values immediately. No pulse is emitted after reset release unless a fresh full debounce completes.
- A button held through reset release is treated as a new press after the full debounce latency.

Optional Feature:
- BLINKER_AUTO_OFF_EN defined:
  - A timeout counter of width $clog2(AUTO_OFF_CYCLES) counts cycles while blinker_switch=1.
  - It clears to 0 on reset, when blinker_switch=0, and on the edge where blinker_switch rises.
  - When it reaches AUTO_OFF_CYCLES-1, blinker_switch←0 on the next edge.
  - Timeout and an accepted press on the same edge: blinker_switch←0; press_pulse still asserts.
- Not defined: no timeout counter; blinker_switch changes only on accepted presses.

Decomposition:
- Package blinker_pkg:
  - state typedef (IDLE, DB_PRESS, HELD, DB_RELEASE) as a 2-bit enum;
  - default DEBOUNCE_CYCLES and AUTO_OFF_CYCLES constants.
- Sub-module sync_2ff (1-bit, async active-low reset to 0) for the synchronizer, reusable by other button inputs.
- Debounce FSM, toggle register and timeout logic stay in blinker_switch_ctrl.

Test Plan (DEBOUNCE_CYCLES=4, AUTO_OFF_CYCLES=16 where relevant):
- Reset check: reset=0 for 3 cycles with btn_raw=1 → all outputs 0. Release reset, hold btn_raw=1 → press_pulse single cycle and btn_stable=1, blinker_switch=1 after edge 6 post-release.
- Glitch rejection: btn_raw=1 for 3 cycles then 0 → btn_stable, press_pulse, blinker_switch stay 0. FSM returns to IDLE.
- Toggle sequence: three clean presses of 10 cycles each, separated by 10-cycle releases → blinker_switch goes 1,0,1. Exactly 3 press_pulse strobes. No strobes on releases.
- Release bounce: while HELD, btn_raw=0 for 2 cycles then 1 → btn_stable stays 1, no pulse.
- Reset mid-debounce: assert reset after btn_raw has been high 3 cycles (counter mid-count) → outputs 0 immediately. After release, a fresh 6-cycle latency is required.
- Auto-off (BLINKER_AUTO_OFF_EN defined): one press, no further input → blinker_switch falls exactly 16 cycles after it rose. Without the macro it stays 1 for ≥100 cycles.
